// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: pipeline control in, I-cache request/response, IF/ID instruction out.
// master = fetch unit side, slave = pipeline/cache environment side.
interface fetch_unit_if;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;
  logic [31:0] IR_IF;
  logic [31:0] PC_IF;
  logic        Fetch_stall;

  modport master (
    input  Stall, Redirect, Redirect_PC, ICACHE_rdata, ICACHE_stall,
    output ICACHE_ren, ICACHE_addr, IR_IF, PC_IF, Fetch_stall
  );

  modport slave (
    output Stall, Redirect, Redirect_PC, ICACHE_rdata, ICACHE_stall,
    input  ICACHE_ren, ICACHE_addr, IR_IF, PC_IF, Fetch_stall
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, I-cache request, hold buffer for IF/ID stalls and
// miss-drain for redirects that arrive while the cache is busy. Zero-latency outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          Clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ibuf;
  logic [31:0] pend_pc;

  logic [31:0] redir_pc;
  logic        take_redir;
  logic        unused_redir_lsbs;

  assign redir_pc          = {bus.Redirect_PC[31:2], 2'b00};
  assign take_redir        = bus.Redirect && !bus.Stall;
  assign unused_redir_lsbs = ^bus.Redirect_PC[1:0];

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pc      <= RESET_PC;
      ibuf    <= 32'h0;
      pend_pc <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (bus.ICACHE_stall) begin
            // Request must stay stable during a miss; park the redirect until it returns.
            if (take_redir) begin
              pend_pc <= redir_pc;
              state   <= DRAIN;
            end
          end else if (bus.Stall) begin
            ibuf  <= bus.ICACHE_rdata;
            state <= HOLD;
          end else begin
            pc <= bus.Redirect ? redir_pc : pc + 32'd4;
          end
        end
        HOLD: begin
          if (!bus.Stall) begin
            pc    <= bus.Redirect ? redir_pc : pc + 32'd4;
            state <= RUN;
          end
        end
        DRAIN: begin
          if (bus.ICACHE_stall) begin
            if (take_redir) pend_pc <= redir_pc;
          end else begin
            pc    <= take_redir ? redir_pc : pend_pc;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    bus.ICACHE_ren  = 1'b0;
    bus.ICACHE_addr = pc[31:2];
    bus.IR_IF       = 32'h0;
    bus.PC_IF       = 32'h0;
    bus.Fetch_stall = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          bus.ICACHE_ren  = 1'b1;
          bus.PC_IF       = pc;
          bus.Fetch_stall = bus.ICACHE_stall;
          bus.IR_IF       = bus.ICACHE_stall ? 32'h0 : bus.ICACHE_rdata;
        end
        HOLD: begin
          bus.IR_IF = ibuf;
          bus.PC_IF = pc;
        end
        DRAIN: begin
          bus.ICACHE_ren  = 1'b1;
          bus.PC_IF       = pc;
          bus.Fetch_stall = bus.ICACHE_stall;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a driver pushes expected outputs from a queue-based
// reference model each cycle; an independent monitor pops and compares on the falling edge.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic Clk = 1'b0;
  logic rst_n;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .Clk  (Clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          chk_addr;
    logic        ren;
    logic [29:0] addr;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        fst;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: current PC, an optional instruction held for IF/ID, and a queue
  // holding at most one redirect target waiting for an outstanding miss to return.
  logic [31:0] m_pc;
  bit          m_held;
  logic [31:0] m_held_word;
  logic [31:0] m_pend[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic m_reset();
    m_pc        = RESET_PC;
    m_held      = 0;
    m_held_word = 32'h0;
    m_pend.delete();
  endtask

  task automatic m_step();
    bit          st  = bus.Stall;
    bit          rd  = bus.Redirect;
    bit          cs  = bus.ICACHE_stall;
    logic [31:0] tgt = align(bus.Redirect_PC);
    logic [31:0] nxt;
    if (m_held) begin
      if (!st) begin
        m_held = 0;
        m_pc   = rd ? tgt : m_pc + 32'd4;
      end
    end else if (m_pend.size() != 0) begin
      if (cs) begin
        if (rd && !st) m_pend[0] = tgt;
      end else begin
        nxt = m_pend.pop_front();
        m_pc = (rd && !st) ? tgt : nxt;
      end
    end else if (cs) begin
      if (rd && !st) m_pend.push_back(tgt);
    end else if (st) begin
      m_held      = 1;
      m_held_word = bus.ICACHE_rdata;
    end else begin
      m_pc = rd ? tgt : m_pc + 32'd4;
    end
  endtask

  task automatic cyc(input bit rv, input bit st, input bit rd, input logic [31:0] rpc,
                     input bit cs, input bit use_word, input logic [31:0] rdat);
    exp_t e;
    @(posedge Clk);
    if (!rst_n) m_reset();
    else m_step();
    #1;
    rst_n            = rv;
    bus.Stall        = st;
    bus.Redirect     = rd;
    bus.Redirect_PC  = rpc;
    bus.ICACHE_stall = cs;
    if (!rv) m_reset();
    bus.ICACHE_rdata = use_word ? word_at(m_pc) : rdat;
    e.chk_addr = 0; e.ren = 0; e.addr = '0; e.ir = 32'h0; e.pc = 32'h0; e.fst = 0;
    if (rv) begin
      e.pc = m_pc;
      if (m_held) begin
        e.ir = m_held_word;
      end else begin
        e.ren      = 1;
        e.chk_addr = 1;
        e.addr     = m_pc[31:2];
        e.fst      = cs;
        e.ir       = (cs || m_pend.size() != 0) ? 32'h0 : bus.ICACHE_rdata;
      end
    end
    sb.push_back(e);
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge Clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if (bus.ICACHE_ren !== e.ren || (e.chk_addr && bus.ICACHE_addr !== e.addr) ||
            bus.IR_IF !== e.ir || bus.PC_IF !== e.pc || bus.Fetch_stall !== e.fst) begin
          miscompares++;
          $display("FAIL vec%0d: got ren=%b addr=%h ir=%h pc=%h fst=%b, want ren=%b addr=%h ir=%h pc=%h fst=%b",
                   vectors, bus.ICACHE_ren, bus.ICACHE_addr, bus.IR_IF, bus.PC_IF, bus.Fetch_stall,
                   e.ren, e.addr, e.ir, e.pc, e.fst);
        end
      end
    end
  end

  initial begin
    rst_n            = 1'b0;
    bus.Stall        = 1'b0;
    bus.Redirect     = 1'b0;
    bus.Redirect_PC  = 32'h0;
    bus.ICACHE_stall = 1'b0;
    bus.ICACHE_rdata = 32'h0;
    m_reset();

    // Reset, sequential hits at 0 and 4, three-cycle miss at 8, then hits at 8 and 12.
    repeat (2) cyc(0, 1, 1, 32'hDEAD_BEEF, 1, 0, 32'hFFFF_FFFF);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 1, 32'h0);
    repeat (3) cyc(1, 0, 0, 32'h0, 1, 0, 32'hBAD0_BAD0);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 1, 32'h0);

    // IF/ID stall on a hit at PC=4; redirect during the hold must be ignored.
    cyc(0, 0, 0, 32'h0, 0, 1, 32'h0);
    cyc(1, 0, 0, 32'h0, 0, 1, 32'h0);
    cyc(1, 1, 0, 32'h0, 0, 0, 32'h2001_0005);
    cyc(1, 1, 1, 32'h0000_0F00, 0, 0, 32'h1234_5678);
    cyc(1, 0, 0, 32'h0, 0, 0, 32'h8765_4321);
    cyc(1, 0, 0, 32'h0, 0, 1, 32'h0);

    // Redirect to 0x103 during a miss at PC=16: drained word discarded, then fetch 0x100.
    cyc(0, 0, 0, 32'h0, 0, 1, 32'h0);
    repeat (4) cyc(1, 0, 0, 32'h0, 0, 1, 32'h0);
    cyc(1, 0, 1, 32'h0000_0103, 1, 0, 32'h0);
    cyc(1, 0, 0, 32'h0, 1, 0, 32'h0);
    cyc(1, 0, 0, 32'h0, 0, 0, 32'hCAFE_F00D);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 1, 32'h0);

    // Wrap at 0xFFFF_FFFC, then reset asserted while draining.
    cyc(1, 0, 1, 32'hFFFF_FFFF, 0, 1, 32'h0);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 1, 32'h0);
    cyc(1, 0, 1, 32'h0000_0200, 1, 0, 32'h0);
    cyc(1, 0, 1, 32'h0000_0300, 1, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 1, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 0, 0, 32'h0);
    repeat (3) cyc(1, 0, 0, 32'h0, 0, 1, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
          $urandom, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) != 0), $urandom);
    end

    @(posedge Clk);
    @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
